// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared pipeline control types and constants
package pipeline_ctrl_pkg;
  typedef enum logic {RUN, DIV_WAIT} ctrl_state_e;
  localparam int DIV_TIMEOUT_DEFAULT = 40;
endpackage

// File: rtl/stall_perf_counter.sv
// stall_perf_counter: wrapping enable counter with synchronous reset
module stall_perf_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge CLK) cnt_q <= RESET ? '0 : cnt_q + W'(en_i);
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: merges hazard, branch, divide and memory waits into per-stage stall/flush controls
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BUBBLE_REQ,
  input  logic        BRANCH_TAKEN,
  input  logic        DIV_START,
  input  logic        DIV_DONE,
  input  logic        IMEM_BUSY,
  input  logic        DMEM_BUSY,
  output logic        PC_STALL,
  output logic        IF_ID_STALL,
  output logic        ID_EX_STALL,
  output logic        EX_MEM_STALL,
  output logic        MEM_WB_STALL,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_FLUSH,
  output logic        EX_MEM_BUBBLE,
  output logic        DIV_BUSY,
  output logic        DIV_ERR,
  output logic [31:0] STALL_CNT
);
  localparam int CW = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_TIMEOUT - 1);
  ctrl_state_e state_q, state_d;
  logic br_pend_q, br_pend_d, done_pend_q, done_pend_d, div_err_q, div_err_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [31:0] stall_cnt;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= RUN;
      br_pend_q   <= 1'b0;
      done_pend_q <= 1'b0;
      div_err_q   <= 1'b0;
      div_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      br_pend_q   <= br_pend_d;
      done_pend_q <= done_pend_d;
      div_err_q   <= div_err_d;
      div_cnt_q   <= div_cnt_d;
    end
  end
  always_comb begin
    PC_STALL      = 1'b0;
    IF_ID_STALL   = 1'b0;
    ID_EX_STALL   = 1'b0;
    EX_MEM_STALL  = 1'b0;
    MEM_WB_STALL  = 1'b0;
    IF_ID_FLUSH   = 1'b0;
    ID_EX_FLUSH   = 1'b0;
    EX_MEM_BUBBLE = 1'b0;
    state_d       = state_q;
    br_pend_d     = br_pend_q;
    done_pend_d   = done_pend_q;
    div_cnt_d     = div_cnt_q;
    div_err_d     = 1'b0;
    if (!RESET) begin
      if (DMEM_BUSY) begin
        // full freeze: remember events that must act once the pipe moves again
        {PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL, MEM_WB_STALL} = 5'b11111;
        br_pend_d   = br_pend_q | BRANCH_TAKEN;
        done_pend_d = done_pend_q | DIV_DONE;
      end else if (state_q == DIV_WAIT) begin
        if (DIV_DONE || done_pend_q) begin
          done_pend_d = 1'b0;
          state_d     = RUN;
        end else begin
          {PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_BUBBLE} = 4'b1111;
          if (div_cnt_q == CNT_LAST) begin
            state_d   = RUN;
            div_err_d = 1'b1;
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
        end
      end else if (BRANCH_TAKEN || br_pend_q) begin
        {IF_ID_FLUSH, ID_EX_FLUSH} = 2'b11;
        br_pend_d = 1'b0;
      end else if (DIV_START) begin
        {PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_BUBBLE} = 4'b1111;
        div_cnt_d = '0;
        state_d   = DIV_WAIT;
      end else if (BUBBLE_REQ) begin
        {PC_STALL, IF_ID_STALL, ID_EX_FLUSH} = 3'b111;
      end else if (IMEM_BUSY) begin
        {PC_STALL, IF_ID_FLUSH} = 2'b11;
      end
    end
  end
  assign DIV_BUSY  = !RESET && (state_q == DIV_WAIT);
  assign DIV_ERR   = !RESET && div_err_q;
  assign STALL_CNT = RESET ? '0 : stall_cnt;
  stall_perf_counter #(.W(32)) u_stall_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .en_i  (PC_STALL),
    .cnt_o (stall_cnt)
  );
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: random plus directed checks of two controller instances against a behavioural model
module tb_pipeline_stall_controller;
  typedef struct packed {logic rst, bub, br, ds, dd, ib, db;} in_t;
  typedef struct {bit div, br, done, err; int waited; logic [31:0] sc;} mdl_t;
  localparam in_t NONE = 7'b0000000, RST = 7'b1000000, BUB = 7'b0100000, BR = 7'b0010000;
  localparam in_t DS = 7'b0001000, DD = 7'b0000100, IB = 7'b0000010, DB = 7'b0000001;
  logic clk = 1'b0, rst, bub, br, ds, dd, ib, db;
  logic [9:0] oa, ow;
  logic [31:0] ca, cw;
  wire a_pc, a_ii, a_ie, a_em, a_mw, a_fi, a_fe, a_bb, a_busy, a_err;
  wire w_pc, w_ii, w_ie, w_em, w_mw, w_fi, w_fe, w_bb, w_busy, w_err;
  wire [31:0] a_cnt, w_cnt;
  int n_chk = 0, n_fail = 0;
  mdl_t ma = '{default: 0}, mw = '{default: 0};
  always #5 clk = ~clk;
  pipeline_stall_controller dut (
    .CLK(clk), .RESET(rst), .BUBBLE_REQ(bub), .BRANCH_TAKEN(br), .DIV_START(ds), .DIV_DONE(dd),
    .IMEM_BUSY(ib), .DMEM_BUSY(db), .PC_STALL(a_pc), .IF_ID_STALL(a_ii), .ID_EX_STALL(a_ie),
    .EX_MEM_STALL(a_em), .MEM_WB_STALL(a_mw), .IF_ID_FLUSH(a_fi), .ID_EX_FLUSH(a_fe),
    .EX_MEM_BUBBLE(a_bb), .DIV_BUSY(a_busy), .DIV_ERR(a_err), .STALL_CNT(a_cnt)
  );
  pipeline_stall_controller #(.DIV_TIMEOUT(4)) dut_wd (
    .CLK(clk), .RESET(rst), .BUBBLE_REQ(bub), .BRANCH_TAKEN(br), .DIV_START(ds), .DIV_DONE(dd),
    .IMEM_BUSY(ib), .DMEM_BUSY(db), .PC_STALL(w_pc), .IF_ID_STALL(w_ii), .ID_EX_STALL(w_ie),
    .EX_MEM_STALL(w_em), .MEM_WB_STALL(w_mw), .IF_ID_FLUSH(w_fi), .ID_EX_FLUSH(w_fe),
    .EX_MEM_BUBBLE(w_bb), .DIV_BUSY(w_busy), .DIV_ERR(w_err), .STALL_CNT(w_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // expected {pc, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall, if_id_flush, id_ex_flush, bubble, busy, err}
  function automatic logic [9:0] exp_out(mdl_t m, in_t x);
    logic [7:0] c = '0;
    if (x.rst) return '0;
    if (x.db) c = 8'b11111000;
    else if (m.div) c = (x.dd || m.done) ? 8'b0 : 8'b11100001;
    else if (x.br || m.br) c = 8'b00000110;
    else if (x.ds) c = 8'b11100001;
    else if (x.bub) c = 8'b11000010;
    else if (x.ib) c = 8'b10000100;
    return {c, 1'(m.div), 1'(m.err)};
  endfunction
  function automatic mdl_t nxt(mdl_t m, in_t x, int t, logic pc);
    mdl_t n = m;
    n.err = 0;
    n.sc = m.sc + 32'(pc);
    if (x.rst) n = '{default: 0};
    else if (x.db) begin
      n.br = m.br | x.br;
      n.done = m.done | x.dd;
    end else if (m.div) begin
      if (x.dd || m.done) {n.done, n.div} = 2'b00;
      else if (m.waited == t - 1) {n.div, n.err} = 2'b01;
      else n.waited = m.waited + 1;
    end else if (x.br || m.br) n.br = 0;
    else if (x.ds) begin
      n.div = 1;
      n.waited = 0;
    end
    return n;
  endfunction
  task automatic step(input in_t x);
    logic [9:0] ea, ew;
    {rst, bub, br, ds, dd, ib, db} = x;
    #3;
    ea = exp_out(ma, x);
    ew = exp_out(mw, x);
    oa = {a_pc, a_ii, a_ie, a_em, a_mw, a_fi, a_fe, a_bb, a_busy, a_err};
    ow = {w_pc, w_ii, w_ie, w_em, w_mw, w_fi, w_fe, w_bb, w_busy, w_err};
    ca = a_cnt;
    cw = w_cnt;
    chk("out_t40", 32'(oa), 32'(ea));
    chk("out_t4", 32'(ow), 32'(ew));
    chk("cnt_t40", ca, x.rst ? 32'd0 : ma.sc);
    chk("cnt_t4", cw, x.rst ? 32'd0 : mw.sc);
    @(posedge clk);
    ma = nxt(ma, x, 40, ea[9]);
    mw = nxt(mw, x, 4, ew[9]);
    #1;
  endtask
  function automatic in_t rnd_in();
    in_t x;
    x.rst = ($urandom_range(59) == 0);
    x.bub = ($urandom_range(3) == 0);
    x.br  = ($urandom_range(5) == 0);
    x.ds  = ($urandom_range(5) == 0);
    x.dd  = ($urandom_range(7) == 0);
    x.ib  = ($urandom_range(3) == 0);
    x.db  = ($urandom_range(4) == 0);
    return x;
  endfunction
  initial begin
    int busy_n, err_n;
    step(RST);
    chk("reset_outs", 32'(oa), 0);
    step(NONE);
    chk("post_reset_outs", 32'(oa), 0);
    chk("post_reset_cnt", ca, 0);
    // five-cycle divide; the timeout-4 instance watchdogs the same sequence
    step(DS);
    chk("div5_pc_t0", 32'(oa[9]), 1);
    chk("div5_bb_t0", 32'(oa[2]), 1);
    for (int i = 1; i < 5; i++) begin
      step(NONE);
      chk("div5_pc", 32'(oa[9]), 1);
      chk("div5_bb", 32'(oa[2]), 1);
    end
    step(DD);
    chk("div5_release_pc", 32'(oa[9]), 0);
    chk("div5_release_bb", 32'(oa[2]), 0);
    chk("wd4_err_after_timeout", 32'(ow[0]), 1);
    step(NONE);
    chk("div5_stall_cnt", ca, 5);
    chk("div5_busy_off", 32'(oa[1]), 0);
    chk("wd4_err_one_cycle", 32'(ow[0]), 0);
    step(RST);
    step(DS);
    busy_n = 0;
    err_n = 0;
    for (int i = 0; i < 7; i++) begin
      step(NONE);
      busy_n += ow[1];
      err_n += ow[0];
    end
    chk("wd_busy_cycles", busy_n, 4);
    chk("wd_err_cycles", err_n, 1);
    chk("wd_state_run", 32'(ow[1]), 0);
    // reset in the middle of a divide
    step(RST);
    step(DS);
    err_n = 0;
    for (int i = 0; i < 3; i++) begin
      step(NONE);
      err_n += oa[0];
    end
    step(RST);
    step(NONE);
    err_n += oa[0];
    chk("rst_mid_busy", 32'(oa[1]), 0);
    chk("rst_mid_cnt", ca, 0);
    chk("rst_mid_no_err", err_n, 0);
    // branch during data freeze
    step(BR | DB);
    chk("frz_stall0", 32'(oa[9:5]), 5'b11111);
    step(DB);
    chk("frz_stall1", 32'(oa[9:5]), 5'b11111);
    chk("frz_noflush", 32'(oa[4:3]), 0);
    step(NONE);
    chk("frz_flush", 32'(oa[4:3]), 2'b11);
    step(NONE);
    chk("frz_flush_once", 32'(oa[4:3]), 0);
    step(BR | BUB | IB);
    chk("prio_br_flush", 32'(oa[4:3]), 2'b11);
    chk("prio_br_pc", 32'(oa[9]), 0);
    step(BUB | IB);
    chk("prio_bub", 32'({oa[9], oa[8], oa[3], oa[4]}), 4'b1110);
    // divide done while frozen
    step(DS);
    step(NONE);
    step(DD | DB);
    step(DB);
    step(NONE);
    chk("done_frz_release", 32'({oa[1], oa[9], oa[2]}), 3'b100);
    step(NONE);
    chk("done_frz_idle", 32'({oa[1], oa[0]}), 0);
    for (int i = 0; i < 2000; i++) step(rnd_in());
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
